// File: rtl/axi_mem_responder.sv
// AXI4 subordinate RAM model: independent write (AW/W/B) and read (AR/R) FSMs, one burst each.
// Latency: wready 1 cycle after AW, bvalid 1 cycle after wlast, first rvalid RD_LATENCY+1 cycles after AR.
// Backpressure: B and R outputs hold while bready/rready are low; awready/arready drop while a burst is active.
module axi_mem_responder #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam int LATW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LATW-1:0] LAT_LAST = LATW'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [IDXW-1:0]     idx;
    logic [7:0]          len;
    logic                incr;
    logic                bad;
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t  w_state;
  burst_t    w_cur;
  logic [7:0] w_beat;
  logic       w_over;

  r_state_t  r_state;
  burst_t    r_cur;
  logic [7:0] r_beat;
  logic [LATW-1:0] r_cnt;

  logic mem_we;
  logic unused_addr;

  // Only the word-index slice of the address matters; the rest is deliberately dropped.
  assign unused_addr = ^{awaddr, araddr};

  // Error bursts and beats past awlen are accepted on the bus but never reach the RAM.
  assign mem_we = wready && wvalid && !w_cur.bad && !w_over && !areset;

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[w_cur.idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_cur   <= '0;
      w_beat  <= '0;
      w_over  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_cur   <= '{id: awid, idx: awaddr[OFFS +: IDXW], len: awlen,
                         incr: (awburst == 2'b01), bad: awburst[1]};
            w_beat  <= '0;
            w_over  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_cur.id;
              bresp   <= (w_cur.bad || w_over || (w_beat != w_cur.len)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              // Once past awlen the burst is only drained until wlast shows up.
              if (w_beat == w_cur.len) w_over <= 1'b1;
              w_beat <= w_beat + 8'd1;
              if (w_cur.incr) w_cur.idx <= w_cur.idx + 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Error bursts still run the full beat count, but with zero data.
  assign rdata = (rvalid && !r_cur.bad) ? mem[r_cur.idx] : '0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      r_cur   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_cur   <= '{id: arid, idx: araddr[OFFS +: IDXW], len: arlen,
                         incr: (arburst == 2'b01), bad: arburst[1]};
            r_beat  <= '0;
            r_cnt   <= '0;
            rid     <= arid;
            rresp   <= arburst[1] ? RESP_SLVERR : RESP_OKAY;
            arready <= 1'b0;
            if (RD_LATENCY == 0) begin
              rvalid  <= 1'b1;
              rlast   <= (arlen == 8'd0);
              r_state <= R_DATA;
            end else begin
              r_state <= R_LAT;
            end
          end
        end
        R_LAT: begin
          if (r_cnt == LAT_LAST) begin
            rvalid  <= 1'b1;
            rlast   <= (r_cur.len == 8'd0);
            r_state <= R_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_beat <= r_beat + 8'd1;
              rlast  <= ((r_beat + 8'd1) == r_cur.len);
              if (r_cur.incr) r_cur.idx <= r_cur.idx + 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, strobes, wrap-around, error bursts, stalls and mid-burst reset.
module tb_axi_mem_responder;

  logic        aclk = 1'b0;
  logic        areset;
  logic [4:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbeats [16];
  logic [3:0]  wstrbs [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [4:0]  rd_id;

  always #5 aclk = ~aclk;

  axi_mem_responder dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic set_beats(input logic [31:0] d0, d1, d2, d3, input logic [3:0] s);
    wbeats[0] = d0; wbeats[1] = d1; wbeats[2] = d2; wbeats[3] = d3;
    for (int i = 0; i < 16; i++) wstrbs[i] = s;
  endtask

  task automatic write_burst(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, output int aw_lat,
                             output int b_lat, output logic [1:0] resp, output logic [4:0] rbid);
    int guard;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(negedge aclk); guard++; end
    @(negedge aclk);
    awvalid = 1'b0;
    aw_lat = 0;
    while (!wready && aw_lat < 50) begin @(negedge aclk); aw_lat++; end
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbeats[i]; wstrb = wstrbs[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 50) begin @(negedge aclk); guard++; end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_lat = 0;
    while (!bvalid && b_lat < 50) begin @(negedge aclk); b_lat++; end
    resp = bresp; rbid = bid;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic read_burst(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [15:0] stall_pat,
                            output int lat, output int stall_bad, output logic rv_after);
    int guard, beat, cyc;
    logic [40:0] snap;
    for (int i = 0; i < 16; i++) begin rd_data[i] = 'x; rd_resp[i] = 'x; rd_last[i] = 'x; end
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge aclk); guard++; end
    @(negedge aclk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge aclk); lat++; end
    beat = 0; cyc = 0; stall_bad = 0;
    while (beat <= int'(len) && cyc < 200) begin
      if (rvalid && stall_pat[cyc % 16]) begin
        rready = 1'b0;
        snap = {rvalid, rdata, rid, rresp, rlast};
        @(negedge aclk);
        if ({rvalid, rdata, rid, rresp, rlast} !== snap) stall_bad++;
      end else if (rvalid) begin
        rready = 1'b1;
        rd_data[beat] = rdata; rd_resp[beat] = rresp; rd_last[beat] = rlast; rd_id = rid;
        @(negedge aclk);
        rready = 1'b0;
        beat++;
      end else begin
        @(negedge aclk);
      end
      cyc++;
    end
    rv_after = rvalid;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arburst = 0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    checks++; if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", {awready, arready}); end
    checks++; if ({wready, bvalid, rvalid, rlast} !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b exp 0000", {wready, bvalid, rvalid, rlast}); end
    checks++; if ({bresp, rresp, bid, rid, rdata} !== '0) begin errors++; $display("FAIL reset_fields got %h exp 0", {bresp, rresp, bid, rid, rdata}); end
  endtask

  task automatic test_incr_write();
    int awl, bl; logic [1:0] rsp; logic [4:0] ib;
    set_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF);
    write_burst(5'h0A, 16'h0010, 8'd3, 2'b01, 4, awl, bl, rsp, ib);
    checks++; if (awl !== 0) begin errors++; $display("FAIL wr_wready_lat got %0d exp 0", awl); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL wr_bvalid_lat got %0d exp 0", bl); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL wr_bresp got %b exp 00", rsp); end
    checks++; if (ib !== 5'h0A) begin errors++; $display("FAIL wr_bid got %h exp 0a", ib); end
  endtask

  task automatic test_incr_read();
    int lat, sb; logic rva;
    logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    read_burst(5'h13, 16'h0010, 8'd3, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (rd_id !== 5'h13) begin errors++; $display("FAIL rd_rid got %h exp 13", rd_id); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== exp_d[i]) begin errors++; $display("FAIL rd_data%0d got %h exp %h", i, rd_data[i], exp_d[i]); end
      checks++; if (rd_last[i] !== (i == 3)) begin errors++; $display("FAIL rd_rlast%0d got %b exp %b", i, rd_last[i], i == 3); end
      checks++; if (rd_resp[i] !== 2'b00) begin errors++; $display("FAIL rd_rresp%0d got %b exp 00", i, rd_resp[i]); end
    end
    checks++; if (rva !== 1'b0) begin errors++; $display("FAIL rd_extra_beat got %b exp 0", rva); end
  endtask

  task automatic test_strobe_fixed();
    int awl, bl, lat, sb; logic [1:0] rsp; logic [4:0] ib; logic rva;
    set_beats(32'hFFFF_FFFF, 0, 0, 0, 4'hF);
    write_burst(5'h01, 16'h0014, 8'd0, 2'b01, 1, awl, bl, rsp, ib);
    set_beats(32'h0000_1234, 0, 0, 0, 4'b0011);
    write_burst(5'h02, 16'h0014, 8'd0, 2'b01, 1, awl, bl, rsp, ib);
    read_burst(5'h03, 16'h0014, 8'd0, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (rd_data[0] !== 32'hFFFF_1234) begin errors++; $display("FAIL strobe_merge got %h exp ffff1234", rd_data[0]); end
    set_beats(32'h7777_7777, 32'h8888_8888, 0, 0, 4'hF);
    write_burst(5'h04, 16'h001C, 8'd1, 2'b01, 2, awl, bl, rsp, ib);
    set_beats(32'h1, 32'h2, 32'h3, 0, 4'hF);
    write_burst(5'h05, 16'h001C, 8'd2, 2'b00, 3, awl, bl, rsp, ib);
    checks++; if (rsp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got %b exp 00", rsp); end
    read_burst(5'h06, 16'h001C, 8'd1, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (rd_data[0] !== 32'h3) begin errors++; $display("FAIL fixed_word7 got %h exp 00000003", rd_data[0]); end
    checks++; if (rd_data[1] !== 32'h8888_8888) begin errors++; $display("FAIL fixed_word8 got %h exp 88888888", rd_data[1]); end
  endtask

  task automatic test_wrap_stall();
    int awl, bl, lat, sb; logic [1:0] rsp; logic [4:0] ib; logic rva;
    logic [31:0] exp_d [4] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    set_beats(32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'hF);
    write_burst(5'h07, 16'h03F8, 8'd3, 2'b01, 4, awl, bl, rsp, ib);
    read_burst(5'h1F, 16'h03F8, 8'd3, 2'b01, 16'b0110_1001_1011_0110, lat, sb, rva);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", i, rd_data[i], exp_d[i]); end
    end
    checks++; if (sb !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", sb); end
    checks++; if (rd_last[3] !== 1'b1 || rd_last[2] !== 1'b0) begin errors++; $display("FAIL stall_rlast got %b%b exp 10", rd_last[3], rd_last[2]); end
    // Upper address bits are ignored, so 0xC000 lands on word 0.
    read_burst(5'h08, 16'hC000, 8'd1, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (rd_data[0] !== 32'hC2 || rd_data[1] !== 32'hC3) begin errors++; $display("FAIL wrap_word0_1 got %h %h exp c2 c3", rd_data[0], rd_data[1]); end
  endtask

  task automatic test_errors();
    int awl, bl, lat, sb; logic [1:0] rsp; logic [4:0] ib; logic rva;
    read_burst(5'h09, 16'h0010, 8'd1, 2'b10, 16'h0000, lat, sb, rva);
    checks++; if ({rd_data[0], rd_data[1]} !== 64'h0) begin errors++; $display("FAIL wrap_rd_data got %h %h exp 0 0", rd_data[0], rd_data[1]); end
    checks++; if ({rd_resp[0], rd_resp[1]} !== 4'b1010) begin errors++; $display("FAIL wrap_rd_resp got %b exp 1010", {rd_resp[0], rd_resp[1]}); end
    checks++; if ({rd_last[0], rd_last[1], rva} !== 3'b010) begin errors++; $display("FAIL wrap_rd_last got %b exp 010", {rd_last[0], rd_last[1], rva}); end
    set_beats(32'hDEAD_BEEF, 0, 0, 0, 4'hF);
    write_burst(5'h0B, 16'h0010, 8'd0, 2'b11, 1, awl, bl, rsp, ib);
    checks++; if (rsp !== 2'b10) begin errors++; $display("FAIL rsvd_bresp got %b exp 10", rsp); end
    read_burst(5'h0C, 16'h0010, 8'd0, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (rd_data[0] !== 32'hA0) begin errors++; $display("FAIL rsvd_ram got %h exp 000000a0", rd_data[0]); end
    set_beats(32'hE0, 32'hE1, 0, 0, 4'hF);
    write_burst(5'h0D, 16'h0040, 8'd3, 2'b01, 2, awl, bl, rsp, ib);
    checks++; if (rsp !== 2'b10 || bl !== 0) begin errors++; $display("FAIL early_wlast got resp %b lat %0d exp 10 0", rsp, bl); end
    set_beats(32'h2020_2020, 32'h2121_2121, 0, 0, 4'hF);
    write_burst(5'h0E, 16'h0050, 8'd1, 2'b01, 2, awl, bl, rsp, ib);
    set_beats(32'hF0, 32'hF1, 0, 0, 4'hF);
    write_burst(5'h0F, 16'h0050, 8'd0, 2'b01, 2, awl, bl, rsp, ib);
    checks++; if (rsp !== 2'b10) begin errors++; $display("FAIL overlong_bresp got %b exp 10", rsp); end
    read_burst(5'h10, 16'h0050, 8'd1, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (rd_data[0] !== 32'hF0 || rd_data[1] !== 32'h2121_2121) begin errors++; $display("FAIL overlong_ram got %h %h exp f0 21212121", rd_data[0], rd_data[1]); end
  endtask

  task automatic test_reset_mid();
    int guard, lat, sb; logic rva;
    @(negedge aclk);
    arid = 5'h11; araddr = 16'h0010; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge aclk); guard++; end
    @(negedge aclk);
    arvalid = 1'b0;
    guard = 0;
    while (!rvalid && guard < 50) begin @(negedge aclk); guard++; end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    checks++; if ({rvalid, rlast, arready} !== 3'b001) begin errors++; $display("FAIL rst_rd got %b exp 001", {rvalid, rlast, arready}); end

    awid = 5'h12; awaddr = 16'h0060; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(negedge aclk); guard++; end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hB0 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 50) begin @(negedge aclk); guard++; end
      @(negedge aclk);
    end
    wvalid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    checks++; if ({wready, bvalid, awready} !== 3'b001) begin errors++; $display("FAIL rst_wr got %b exp 001", {wready, bvalid, awready}); end
    repeat (3) @(negedge aclk);
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL rst_no_resp got %b exp 00", {bvalid, rvalid}); end
    read_burst(5'h14, 16'h0060, 8'd1, 2'b01, 16'h0000, lat, sb, rva);
    checks++; if (rd_data[0] !== 32'hB0 || rd_data[1] !== 32'hB1) begin errors++; $display("FAIL rst_persist got %h %h exp b0 b1", rd_data[0], rd_data[1]); end
  endtask

  initial begin
    test_reset();
    test_incr_write();
    test_incr_read();
    test_strobe_fixed();
    test_wrap_stall();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
